// File: rtl/rat_path_queue.sv
// Linear move buffer: stores 2-bit path moves, replays one per accepted dequeue and tracks (x,y).
// dout/pos/move_valid are valid 1 cycle after the dequeue edge; writes into a full buffer are dropped and flagged.
module rat_path_queue #(
  parameter int DEPTH = 256,
  parameter int N     = 4,
  localparam int AW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enqueue,
  input  logic [1:0]    din,
  input  logic          enMBuff,
  input  logic          dequeue,
  input  logic          recover,
  output logic [1:0]    dout,
  output logic          move_valid,
  output logic          emptyq,
  output logic          full,
  output logic [AW-1:0] count,
  output logic [N-1:0]  pos_x,
  output logic [N-1:0]  pos_y,
  output logic          overflow
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [1:0]    r_dout;
  logic          r_move_valid;
  logic [N-1:0]  r_pos_x;
  logic [N-1:0]  r_pos_y;
  logic          r_overflow;

  logic          w_empty;
  logic          w_full;
  logic          w_deq_ok;
  logic          w_wr_en;
  logic [1:0]    w_head;

  assign w_empty  = (r_rd_ptr == r_wr_ptr);
  assign w_full   = (r_wr_ptr == AW'(DEPTH));
  assign w_deq_ok = dequeue && enMBuff && !w_empty;
  assign w_wr_en  = !clear && !recover && enqueue && !w_full;
  assign w_head   = r_mem[r_rd_ptr[IW-1:0]];

  // Storage is never reset or cleared so that recover can replay the old path.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[IW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_dout       <= 2'b00;
      r_move_valid <= 1'b0;
      r_pos_x      <= '0;
      r_pos_y      <= '0;
      r_overflow   <= 1'b0;
    end else if (clear) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_dout       <= 2'b00;
      r_move_valid <= 1'b0;
      r_pos_x      <= '0;
      r_pos_y      <= '0;
      r_overflow   <= 1'b0;
    end else if (recover) begin
      r_rd_ptr     <= '0;
      r_move_valid <= 1'b0;
      r_pos_x      <= '0;
      r_pos_y      <= '0;
    end else begin
      if (enqueue) begin
        if (w_full) begin
          r_overflow <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
      end
      r_move_valid <= w_deq_ok;
      if (w_deq_ok) begin
        r_dout   <= w_head;
        r_rd_ptr <= r_rd_ptr + AW'(1);
        // 00/11 move along x, 01/10 along y; wraps modulo 2^N.
        case (w_head)
          2'b00:   r_pos_x <= r_pos_x + N'(1);
          2'b11:   r_pos_x <= r_pos_x - N'(1);
          2'b01:   r_pos_y <= r_pos_y + N'(1);
          default: r_pos_y <= r_pos_y - N'(1);
        endcase
      end
    end
  end

  assign dout       = r_dout;
  assign move_valid = r_move_valid;
  assign emptyq     = w_empty;
  assign full       = w_full;
  assign count      = r_wr_ptr - r_rd_ptr;
  assign pos_x      = r_pos_x;
  assign pos_y      = r_pos_y;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_rat_path_queue.sv
module tb_rat_path_queue;
  localparam int DEPTH = 8;
  localparam int N     = 4;
  localparam int AW    = $clog2(DEPTH + 1);
  localparam int WRAP  = 1 << N;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0, enqueue = 1'b0, enMBuff = 1'b0, dequeue = 1'b0, recover = 1'b0;
  logic [1:0]    din = 2'b00;
  logic [1:0]    dout;
  logic          move_valid, emptyq, full, overflow;
  logic [AW-1:0] count;
  logic [N-1:0]  pos_x, pos_y;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  rat_path_queue #(.DEPTH(DEPTH), .N(N)) dut (
    .clk(clk), .rst(rst), .clear(clear), .enqueue(enqueue), .din(din),
    .enMBuff(enMBuff), .dequeue(dequeue), .recover(recover), .dout(dout),
    .move_valid(move_valid), .emptyq(emptyq), .full(full), .count(count),
    .pos_x(pos_x), .pos_y(pos_y), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference: a plain array of moves, two integer indices and an integer position.
  bit [1:0] m_mem [DEPTH];
  int m_wr, m_rd, m_x, m_y;
  bit [1:0] m_dout;
  bit m_mv, m_ovf;

  always @(posedge clk or negedge rst) begin
    if (!rst || clear) begin
      m_wr = 0; m_rd = 0; m_x = 0; m_y = 0; m_dout = 0; m_mv = 0; m_ovf = 0;
    end else if (recover) begin
      m_rd = 0; m_x = 0; m_y = 0; m_mv = 0;
    end else begin
      bit take;
      take = dequeue && enMBuff && (m_rd != m_wr);
      m_mv = take;
      if (take) begin
        m_dout = m_mem[m_rd];
        m_rd++;
        if (m_dout == 2'b00) m_x = (m_x + 1) % WRAP;
        else if (m_dout == 2'b11) m_x = (m_x + WRAP - 1) % WRAP;
        else if (m_dout == 2'b01) m_y = (m_y + 1) % WRAP;
        else m_y = (m_y + WRAP - 1) % WRAP;
      end
      if (enqueue) begin
        if (m_wr == DEPTH) m_ovf = 1;
        else begin m_mem[m_wr] = din; m_wr++; end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_emptyq",   32'(emptyq),     32'(m_rd == m_wr));
      chk("m_full",     32'(full),       32'(m_wr == DEPTH));
      chk("m_count",    32'(count),      32'(m_wr - m_rd));
      chk("m_dout",     32'(dout),       32'(m_dout));
      chk("m_valid",    32'(move_valid), 32'(m_mv));
      chk("m_pos_x",    32'(pos_x),      32'(m_x));
      chk("m_pos_y",    32'(pos_y),      32'(m_y));
      chk("m_overflow", 32'(overflow),   32'(m_ovf));
    end
  end

  task automatic cyc(bit enq, bit [1:0] d, bit deq, bit en, bit rec, bit clr);
    enqueue = enq; din = d; dequeue = deq; enMBuff = en; recover = rec; clear = clr;
    @(posedge clk); #1;
    enqueue = 0; dequeue = 0; recover = 0; clear = 0;
  endtask

  bit [1:0] path [5] = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b10};
  int exp_x [5] = '{1, 2, 2, 1, 1};
  int exp_y [5] = '{0, 0, 1, 1, 0};

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    chk("rst_empty", 32'(emptyq), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_valid", 32'(move_valid), 0);

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 3; i++) cyc(1, 2'(i), 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    chk("pre_rst_count", 32'(count), 2);
    #2 rst = 1'b0;
    #1;
    chk("arst_empty", 32'(emptyq), 1);
    chk("arst_count", 32'(count), 0);
    chk("arst_pos_x", 32'(pos_x), 0);
    chk("arst_valid", 32'(move_valid), 0);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    // Five-move path, then replay after recover.
    for (int i = 0; i < 5; i++) cyc(1, path[i], 0, 1, 0, 0);
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 5; i++) begin
        cyc(0, 0, 1, 1, 0, 0);
        chk("path_dout", 32'(dout), 32'(path[i]));
        chk("path_x", 32'(pos_x), 32'(exp_x[i]));
        chk("path_y", 32'(pos_y), 32'(exp_y[i]));
        chk("path_valid", 32'(move_valid), 1);
      end
      chk("path_empty", 32'(emptyq), 1);
      cyc(0, 0, 1, 1, 0, 0);
      chk("empty_deq_dout", 32'(dout), 32'(2'b10));
      chk("empty_deq_valid", 32'(move_valid), 0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("recover_count", 32'(count), 5);
      chk("recover_x", 32'(pos_x), 0);
    end

    // Wrap below zero, and enMBuff gating.
    cyc(0, 0, 0, 0, 0, 1);
    cyc(1, 2'b11, 0, 1, 0, 0);
    cyc(1, 2'b10, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    chk("wrap_x", 32'(pos_x), 15);
    cyc(0, 0, 1, 1, 0, 0);
    chk("wrap_y", 32'(pos_y), 15);
    cyc(1, 2'b00, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("noen_count", 32'(count), 1);
    chk("noen_valid", 32'(move_valid), 0);

    // Fill, overflow, and dequeue alongside a dropped write.
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc(1, 2'(i), 0, 1, 0, 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf", 32'(overflow), 0);
    cyc(1, 0, 0, 1, 0, 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_count", 32'(count), DEPTH);
    cyc(1, 0, 1, 1, 0, 0);
    chk("full_enq_deq_count", 32'(count), DEPTH - 1);

    // clear beats recover beats enqueue.
    cyc(1, 2'b01, 0, 1, 1, 1);
    chk("prio_empty", 32'(emptyq), 1);
    chk("prio_count", 32'(count), 0);
    chk("prio_ovf", 32'(overflow), 0);
    cyc(1, 2'b01, 0, 1, 0, 0);
    cyc(1, 2'b01, 1, 1, 1, 0);
    chk("rec_enq_count", 32'(count), 1);

    // Randomised traffic against the reference.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(1, 0) == 1, 2'($urandom), $urandom_range(1, 0) == 1,
          $urandom_range(3, 0) != 0, $urandom_range(31, 0) == 0, $urandom_range(63, 0) == 0);
    end

    @(negedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
